// File: rtl/reaction_measure.sv
// rtl/reaction_measure.sv - reaction timer controller: arms the delay, lights the LED, measures ms to press
module reaction_measure #(
    parameter int TICKS_PER_MS = 50000,
    parameter int TIMEOUT_MS   = 2000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Button,
    input  logic        finished,
    output logic        Control,
    output logic        LED,
    output logic [11:0] ReactionTime,
    output logic        Valid,
    output logic        Early,
    output logic        Timeout
);

    localparam int              PW      = $clog2(TICKS_PER_MS);
    localparam logic [PW-1:0]   PRE_MAX = PW'(TICKS_PER_MS - 1);
    localparam logic [11:0]     TO_MS   = 12'(TIMEOUT_MS);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] TIMING = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]    state;
    logic          sync1, sync2, prev;
    logic [PW-1:0] prescale;
    logic [11:0]   ms_count;
    logic          press;

    // Rising edge of the synchronized button, so a held button counts once.
    assign press   = sync2 & ~prev;
    assign Control = (state == ARMED) || (state == TIMING);
    assign LED     = (state == TIMING);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            prev         <= 1'b0;
            prescale     <= '0;
            ms_count     <= '0;
            ReactionTime <= '0;
            Valid        <= 1'b0;
            Early        <= 1'b0;
            Timeout      <= 1'b0;
        end else begin
            sync1 <= Button;
            sync2 <= sync1;
            prev  <= sync2;
            case (state)
                IDLE: begin
                    if (Start) state <= ARMED;
                end
                ARMED: begin
                    if (press) begin
                        state        <= DONE;
                        Early        <= 1'b1;
                        ReactionTime <= '0;
                    end else if (finished) begin
                        state    <= TIMING;
                        prescale <= '0;
                        ms_count <= '0;
                    end
                end
                TIMING: begin
                    if (press) begin
                        state        <= DONE;
                        Valid        <= 1'b1;
                        ReactionTime <= ms_count;
                    end else if (ms_count == TO_MS) begin
                        state        <= DONE;
                        Timeout      <= 1'b1;
                        ReactionTime <= TO_MS;
                    end else if (prescale == PRE_MAX) begin
                        // ms_count stops at TO_MS because the branch above exits first.
                        prescale <= '0;
                        ms_count <= ms_count + 12'd1;
                    end else begin
                        prescale <= prescale + 1'b1;
                    end
                end
                DONE: begin
                    if (Start) begin
                        state        <= ARMED;
                        ReactionTime <= '0;
                        Valid        <= 1'b0;
                        Early        <= 1'b0;
                        Timeout      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_measure.sv
// tb/tb_reaction_measure.sv - self-checking bench for reaction_measure with an event-level model
module tb_reaction_measure;

    localparam int T  = 4;
    localparam int TO = 10;

    logic        Clock = 1'b0;
    logic        Reset, Start, Button, finished;
    logic        Control, LED, Valid, Early, Timeout;
    logic [11:0] ReactionTime;

    int checks = 0;
    int errors = 0;

    reaction_measure #(.TICKS_PER_MS(T), .TIMEOUT_MS(TO)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Button(Button),
        .finished(finished), .Control(Control), .LED(LED),
        .ReactionTime(ReactionTime), .Valid(Valid), .Early(Early), .Timeout(Timeout)
    );

    always #5 Clock = ~Clock;

    // Model: edge count, button sample history, trial phase and start edge of timing.
    int n = 0;
    int last_reset = 0;
    bit hist [0:16383];
    int phase = 0;  // 0 idle, 1 armed, 2 timing, 3 done
    int t0 = 0;
    int m_rt = 0;
    bit m_valid = 0, m_early = 0, m_timeout = 0;
    bit model_on = 0;

    function automatic bit sample(input int i);
        if (i <= last_reset) return 1'b0;
        return hist[i];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit f);
        bit p;
        int ms;
        // A press is acted on two edges after the button is first sampled high.
        p = sample(n - 2) && !sample(n - 3);
        if (r) begin
            last_reset = n;
            phase = 0;
            m_rt = 0; m_valid = 0; m_early = 0; m_timeout = 0;
            model_on = 1;
        end else begin
            case (phase)
                0: if (s) phase = 1;
                1: begin
                    if (p) begin
                        phase = 3; m_early = 1; m_rt = 0;
                    end else if (f) begin
                        phase = 2; t0 = n;
                    end
                end
                2: begin
                    ms = (n - 1 - t0) / T;
                    if (ms > TO) ms = TO;
                    if (p) begin
                        phase = 3; m_valid = 1; m_rt = ms;
                    end else if (ms == TO) begin
                        phase = 3; m_timeout = 1; m_rt = TO;
                    end
                end
                default: begin
                    if (s) begin
                        phase = 1;
                        m_rt = 0; m_valid = 0; m_early = 0; m_timeout = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit b, input bit f);
        Reset = r; Start = s; Button = b; finished = f;
        @(posedge Clock);
        n++;
        hist[n] = b;
        model_step(r, s, f);
        #1;
    endtask

    always @(negedge Clock) begin
        if (model_on) begin
            chk("control", int'(Control), int'(phase == 1 || phase == 2));
            chk("led", int'(LED), int'(phase == 2));
            chk("reaction_time", int'(ReactionTime), m_rt);
            chk("valid", int'(Valid), int'(m_valid));
            chk("early", int'(Early), int'(m_early));
            chk("timeout", int'(Timeout), int'(m_timeout));
        end
    end

    initial begin
        bit btn;
        // Reset with random inputs
        repeat (2) cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        chk("rst_control", int'(Control), 0);
        chk("rst_led", int'(LED), 0);
        chk("rst_rt", int'(ReactionTime), 0);
        chk("rst_flags", int'({Valid, Early, Timeout}), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'($urandom));
        chk("idle_stays", int'(Control), 0);
        repeat (3) cyc(0, 0, 0, 0);

        // Normal trial
        cyc(0, 1, 0, 0);
        chk("arm_control", int'(Control), 1);
        repeat (19) cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("timing_led", int'(LED), 1);
        repeat (27) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        chk("normal_not_yet", int'(Valid), 0);
        cyc(0, 0, 1, 0);
        chk("normal_valid", int'(Valid), 1);
        chk("normal_rt", int'(ReactionTime), 7);
        chk("normal_led_off", int'(LED), 0);
        chk("normal_ctrl_off", int'(Control), 0);
        repeat (3) cyc(0, 0, 0, 0);

        // Early press, later finished ignored
        cyc(0, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 0);
        chk("early_flag", int'(Early), 1);
        chk("early_rt", int'(ReactionTime), 0);
        chk("early_valid", int'(Valid), 0);
        cyc(0, 0, 0, 1);
        chk("early_fin_led", int'(LED), 0);

        // Start from DONE clears Early; press and finished together gives Early
        cyc(0, 1, 0, 0);
        chk("restart_clear", int'(Early), 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        chk("simul_early", int'(Early), 1);
        chk("simul_led", int'(LED), 0);

        // Held button across a re-armed trial yields no second press; then timeout
        repeat (2) cyc(0, 0, 1, 0);
        cyc(0, 1, 1, 0);
        repeat (5) cyc(0, 0, 1, 0);
        chk("held_no_early", int'(Early), 0);
        cyc(0, 0, 1, 1);
        chk("held_led", int'(LED), 1);
        repeat (40) cyc(0, 0, 1, 0);
        chk("timeout_not_yet", int'(Timeout), 0);
        cyc(0, 0, 1, 0);
        chk("timeout_flag", int'(Timeout), 1);
        chk("timeout_rt", int'(ReactionTime), 10);
        chk("timeout_valid", int'(Valid), 0);
        repeat (2) cyc(0, 0, 0, 0);
        repeat (4) cyc(0, 0, 1, 0);
        chk("timeout_held", int'(Timeout), 1);
        chk("timeout_rt_held", int'(ReactionTime), 10);

        // Ignored start and mid-trial reset
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk("start_ignored", int'(LED), 1);
        repeat (15) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("midrst_ctrl", int'(Control), 0);
        chk("midrst_led", int'(LED), 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        repeat (9) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("after_rst_valid", int'(Valid), 1);
        chk("after_rst_rt", int'(ReactionTime), 2);

        // Randomized traffic against the model
        btn = 1'b0;
        repeat (3000) begin
            if ($urandom_range(0, 11) == 0) btn = ~btn;
            cyc(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 24) == 0),
                btn, 1'($urandom_range(0, 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
